// File: rtl/ecg_dpram_ctrl.sv
// ecg_dpram_ctrl: single-clock true dual-port sample RAM with selectable read latency,
// collision arbitration (port A wins) and a saturating write counter. Optional parity: DPRAM_PARITY_EN.
`timescale 1ns/1ps
module ecg_dpram_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0
) (
    input  logic              Clk,
    input  logic              Rstn,
    input  logic              Ena,
    input  logic              Wea,
    input  logic [ADDR_W-1:0] Addra,
    input  logic [DATA_W-1:0] Dina,
    output logic [DATA_W-1:0] Douta,
    output logic              Valida,
    input  logic              Enb,
    input  logic              Web,
    input  logic [ADDR_W-1:0] Addrb,
    input  logic [DATA_W-1:0] Dinb,
    output logic [DATA_W-1:0] Doutb,
    output logic              Validb,
    output logic              Collision,
    output logic [ADDR_W:0]   WrCount
`ifdef DPRAM_PARITY_EN
    ,
    output logic              ParErra,
    output logic              ParErrb
`endif
);

`ifdef DPRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W+1:0] WR_MAX = {2'b01, {ADDR_W{1'b0}}};

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DPRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W+1:0] s);
        if (s > WR_MAX)
            return WR_MAX[ADDR_W:0];
        return s[ADDR_W:0];
    endfunction

    logic [MEM_W-1:0] mem [DEPTH];

    logic              same_addr, wr_a, wr_b, rd_a, rd_b, coll;
    logic [1:0]        n_wr;
    logic [ADDR_W+1:0] cnt_sum;
    logic [MEM_W-1:0]  rword_a, rword_b;

    always_comb begin
        same_addr = (Addra == Addrb);
        wr_a      = Rstn && Ena && Wea;
        coll      = wr_a && Enb && Web && same_addr;
        wr_b      = Rstn && Enb && Web && !coll;
        rd_a      = Rstn && Ena && !Wea;
        rd_b      = Rstn && Enb && !Web;
        n_wr      = {1'b0, wr_a} + {1'b0, wr_b};
        cnt_sum   = {1'b0, WrCount} + {{ADDR_W{1'b0}}, n_wr};
    end

    // Cross-port read-during-write: the array read is pre-write; forwarding replaces it when enabled.
    always_comb begin
        rword_a = mem[Addra];
        rword_b = mem[Addrb];
        if (RDW_NEW != 0) begin
            if (wr_b && same_addr)
                rword_a = encode(Dinb);
            if (wr_a && same_addr)
                rword_b = encode(Dina);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_a)
            mem[Addra] <= encode(Dina);
        if (wr_b)
            mem[Addrb] <= encode(Dinb);
    end

    logic [MEM_W-1:0] dat_a_p0, dat_b_p0, dat_a_p1, dat_b_p1;
    logic             vld_a_p0, vld_b_p0, vld_a_p1, vld_b_p1;

    // Stage p0: array read register; stage p1: optional extra output register.
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            dat_a_p0  <= '0;
            dat_b_p0  <= '0;
            dat_a_p1  <= '0;
            dat_b_p1  <= '0;
            vld_a_p0  <= 1'b0;
            vld_b_p0  <= 1'b0;
            vld_a_p1  <= 1'b0;
            vld_b_p1  <= 1'b0;
            Collision <= 1'b0;
            WrCount   <= '0;
        end else begin
            vld_a_p0 <= rd_a;
            vld_b_p0 <= rd_b;
            if (rd_a)
                dat_a_p0 <= rword_a;
            if (rd_b)
                dat_b_p0 <= rword_b;
            vld_a_p1 <= vld_a_p0;
            vld_b_p1 <= vld_b_p0;
            if (vld_a_p0)
                dat_a_p1 <= dat_a_p0;
            if (vld_b_p0)
                dat_b_p1 <= dat_b_p0;
            Collision <= coll;
            WrCount   <= sat_count(cnt_sum);
        end
    end

    logic [MEM_W-1:0] out_a, out_b;

    always_comb begin
        if (RD_LAT == 2) begin
            out_a  = dat_a_p1;
            out_b  = dat_b_p1;
            Valida = vld_a_p1;
            Validb = vld_b_p1;
        end else begin
            out_a  = dat_a_p0;
            out_b  = dat_b_p0;
            Valida = vld_a_p0;
            Validb = vld_b_p0;
        end
        Douta = out_a[DATA_W-1:0];
        Doutb = out_b[DATA_W-1:0];
    end

`ifdef DPRAM_PARITY_EN
    // Stored word plus parity bit XORs to zero when intact.
    always_comb begin
        ParErra = Valida && (^out_a);
        ParErrb = Validb && (^out_b);
    end
`endif

endmodule

// File: tb/tb_ecg_dpram_ctrl.sv
// Directed bench for ecg_dpram_ctrl: u1 uses defaults (RD_LAT=1, old-data RDW),
// u2 uses ADDR_W=2, RD_LAT=2, new-data RDW; both share the same stimulus.
`timescale 1ns/1ps
module tb_ecg_dpram_ctrl;

    logic        Clk = 1'b0;
    logic        Rstn;
    logic        Ena, Wea, Enb, Web;
    logic [11:0] Addra, Addrb;
    logic [31:0] Dina, Dinb;

    logic [31:0] douta1, doutb1, douta2, doutb2;
    logic        valida1, validb1, coll1, valida2, validb2, coll2;
    logic [12:0] wrc1;
    logic [2:0]  wrc2;
`ifdef DPRAM_PARITY_EN
    logic        parerra1, parerrb1, parerra2, parerrb2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ecg_dpram_ctrl #(.DATA_W(32), .ADDR_W(12), .RD_LAT(1), .RDW_NEW(0)) u1 (
        .Clk(Clk), .Rstn(Rstn),
        .Ena(Ena), .Wea(Wea), .Addra(Addra), .Dina(Dina), .Douta(douta1), .Valida(valida1),
        .Enb(Enb), .Web(Web), .Addrb(Addrb), .Dinb(Dinb), .Doutb(doutb1), .Validb(validb1),
        .Collision(coll1), .WrCount(wrc1)
`ifdef DPRAM_PARITY_EN
        , .ParErra(parerra1), .ParErrb(parerrb1)
`endif
    );

    ecg_dpram_ctrl #(.DATA_W(32), .ADDR_W(2), .RD_LAT(2), .RDW_NEW(1)) u2 (
        .Clk(Clk), .Rstn(Rstn),
        .Ena(Ena), .Wea(Wea), .Addra(Addra[1:0]), .Dina(Dina), .Douta(douta2), .Valida(valida2),
        .Enb(Enb), .Web(Web), .Addrb(Addrb[1:0]), .Dinb(Dinb), .Doutb(doutb2), .Validb(validb2),
        .Collision(coll2), .WrCount(wrc2)
`ifdef DPRAM_PARITY_EN
        , .ParErra(parerra2), .ParErrb(parerrb2)
`endif
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Ena = 1'b0; Wea = 1'b0; Enb = 1'b0; Web = 1'b0;
    endtask

    task automatic test_reset();
        Rstn = 1'b0; idle();
        Addra = '0; Addrb = '0; Dina = '0; Dinb = '0;
        tick(); tick();
        checks++; if (douta1 !== 32'h0) begin errors++; $display("FAIL rst_douta1 got %h want 0", douta1); end
        checks++; if (doutb1 !== 32'h0) begin errors++; $display("FAIL rst_doutb1 got %h want 0", doutb1); end
        checks++; if (valida1 !== 1'b0 || validb1 !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %b%b want 00", valida1, validb1); end
        checks++; if (coll1 !== 1'b0) begin errors++; $display("FAIL rst_coll1 got %b want 0", coll1); end
        checks++; if (wrc1 !== 13'd0) begin errors++; $display("FAIL rst_wrc1 got %0d want 0", wrc1); end
        checks++; if (douta2 !== 32'h0 || valida2 !== 1'b0 || wrc2 !== 3'd0) begin errors++; $display("FAIL rst_u2 got %h %b %0d want 0 0 0", douta2, valida2, wrc2); end
        Rstn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] vals [4];
        vals[0] = 32'h41400000; vals[1] = 32'hBEE9D495; vals[2] = 32'h3E6C8B44; vals[3] = 32'h42C80000;
        for (int i = 0; i < 4; i++) begin
            Ena = 1'b1; Wea = 1'b1; Addra = 12'(i); Dina = vals[i];
            tick();
            checks++; if (valida1 !== 1'b0) begin errors++; $display("FAIL wr_no_valida step %0d got %b want 0", i, valida1); end
        end
        checks++; if (wrc1 !== 13'd4) begin errors++; $display("FAIL wr_count1 got %0d want 4", wrc1); end
        checks++; if (wrc2 !== 3'd4) begin errors++; $display("FAIL wr_count2 got %0d want 4", wrc2); end
        idle(); Enb = 1'b1; Web = 1'b0; Addrb = 12'd1;
        tick();
        Addrb = 12'd3;
        checks++; if (doutb1 !== 32'hBEE9D495 || validb1 !== 1'b1) begin errors++; $display("FAIL rd1_addr1 got %h/%b want BEE9D495/1", doutb1, validb1); end
        checks++; if (validb2 !== 1'b0) begin errors++; $display("FAIL rd2_early got %b want 0", validb2); end
        tick();
        idle();
        checks++; if (doutb1 !== 32'h42C80000 || validb1 !== 1'b1) begin errors++; $display("FAIL rd1_addr3 got %h/%b want 42C80000/1", doutb1, validb1); end
        checks++; if (doutb2 !== 32'hBEE9D495 || validb2 !== 1'b1) begin errors++; $display("FAIL rd2_addr1 got %h/%b want BEE9D495/1", doutb2, validb2); end
        tick();
        checks++; if (validb1 !== 1'b0 || doutb1 !== 32'h42C80000) begin errors++; $display("FAIL rd1_hold got %h/%b want 42C80000/0", doutb1, validb1); end
        checks++; if (doutb2 !== 32'h42C80000 || validb2 !== 1'b1) begin errors++; $display("FAIL rd2_addr3 got %h/%b want 42C80000/1", doutb2, validb2); end
        tick();
        checks++; if (validb2 !== 1'b0) begin errors++; $display("FAIL rd2_end got %b want 0", validb2); end
    endtask

    task automatic test_rd_lat2();
        Ena = 1'b1; Wea = 1'b0; Addra = 12'd0;
        tick();
        Addra = 12'd2;
        checks++; if (douta1 !== 32'h41400000 || valida1 !== 1'b1) begin errors++; $display("FAIL lat1_a0 got %h/%b want 41400000/1", douta1, valida1); end
        checks++; if (valida2 !== 1'b0) begin errors++; $display("FAIL lat2_n1 got %b want 0", valida2); end
        tick();
        idle();
        checks++; if (douta1 !== 32'h3E6C8B44 || valida1 !== 1'b1) begin errors++; $display("FAIL lat1_a2 got %h/%b want 3E6C8B44/1", douta1, valida1); end
        checks++; if (douta2 !== 32'h41400000 || valida2 !== 1'b1) begin errors++; $display("FAIL lat2_a0 got %h/%b want 41400000/1", douta2, valida2); end
        tick();
        checks++; if (valida1 !== 1'b0) begin errors++; $display("FAIL lat1_end got %b want 0", valida1); end
        checks++; if (douta2 !== 32'h3E6C8B44 || valida2 !== 1'b1) begin errors++; $display("FAIL lat2_a2 got %h/%b want 3E6C8B44/1", douta2, valida2); end
        tick();
        checks++; if (valida2 !== 1'b0 || douta2 !== 32'h3E6C8B44) begin errors++; $display("FAIL lat2_end got %h/%b want 3E6C8B44/0", douta2, valida2); end
    endtask

    task automatic test_collision();
        Ena = 1'b1; Wea = 1'b1; Addra = 12'd5; Dina = 32'h3F800000;
        Enb = 1'b1; Web = 1'b1; Addrb = 12'd5; Dinb = 32'h40000000;
        tick();
        idle();
        checks++; if (coll1 !== 1'b1 || coll2 !== 1'b1) begin errors++; $display("FAIL coll_pulse got %b%b want 11", coll1, coll2); end
        checks++; if (wrc1 !== 13'd5) begin errors++; $display("FAIL coll_wrc1 got %0d want 5", wrc1); end
        checks++; if (wrc2 !== 3'd4) begin errors++; $display("FAIL coll_wrc2 got %0d want 4", wrc2); end
        Enb = 1'b1; Web = 1'b0; Addrb = 12'd5;
        tick();
        idle();
        checks++; if (coll1 !== 1'b0 || coll2 !== 1'b0) begin errors++; $display("FAIL coll_once got %b%b want 00", coll1, coll2); end
        checks++; if (doutb1 !== 32'h3F800000) begin errors++; $display("FAIL coll_rd1 got %h want 3F800000", doutb1); end
        tick();
        checks++; if (doutb2 !== 32'h3F800000 || validb2 !== 1'b1) begin errors++; $display("FAIL coll_rd2 got %h/%b want 3F800000/1", doutb2, validb2); end
    endtask

    task automatic test_rdw();
        Ena = 1'b1; Wea = 1'b1; Addra = 12'd7; Dina = 32'h11111111;
        tick();
        Dina = 32'h22222222; Enb = 1'b1; Web = 1'b0; Addrb = 12'd7;
        tick();
        idle();
        checks++; if (doutb1 !== 32'h11111111 || validb1 !== 1'b1) begin errors++; $display("FAIL rdw_old_b got %h/%b want 11111111/1", doutb1, validb1); end
        tick();
        checks++; if (doutb2 !== 32'h22222222 || validb2 !== 1'b1) begin errors++; $display("FAIL rdw_new_b got %h/%b want 22222222/1", doutb2, validb2); end
        Enb = 1'b1; Web = 1'b1; Addrb = 12'd7; Dinb = 32'h33333333;
        Ena = 1'b1; Wea = 1'b0; Addra = 12'd7;
        tick();
        idle();
        checks++; if (douta1 !== 32'h22222222) begin errors++; $display("FAIL rdw_old_a got %h want 22222222", douta1); end
        tick();
        checks++; if (douta2 !== 32'h33333333) begin errors++; $display("FAIL rdw_new_a got %h want 33333333", douta2); end
        Enb = 1'b1; Web = 1'b0; Addrb = 12'd7;
        tick();
        idle();
        checks++; if (doutb1 !== 32'h33333333) begin errors++; $display("FAIL rdw_stored got %h want 33333333", doutb1); end
    endtask

    task automatic test_saturate_reset();
        Rstn = 1'b0; idle();
        tick();
        Rstn = 1'b1;
        checks++; if (wrc1 !== 13'd0 || wrc2 !== 3'd0) begin errors++; $display("FAIL sat_clear got %0d/%0d want 0/0", wrc1, wrc2); end
        Ena = 1'b1; Wea = 1'b1;
        Addra = 12'd0; Dina = 32'hA0A0A0A0; tick();
        Addra = 12'd1; Dina = 32'hA1A1A1A1; tick();
        Addra = 12'd2; Dina = 32'hA2A2A2A2; tick();
        checks++; if (wrc1 !== 13'd3 || wrc2 !== 3'd3) begin errors++; $display("FAIL sat_three got %0d/%0d want 3/3", wrc1, wrc2); end
        Addra = 12'd0; Dina = 32'hCAFEF00D;
        Enb = 1'b1; Web = 1'b1; Addrb = 12'd3; Dinb = 32'h0BADBEEF;
        tick();
        checks++; if (wrc1 !== 13'd5) begin errors++; $display("FAIL sat_dual1 got %0d want 5", wrc1); end
        checks++; if (wrc2 !== 3'd4) begin errors++; $display("FAIL sat_clamp2 got %0d want 4", wrc2); end
        checks++; if (coll1 !== 1'b0) begin errors++; $display("FAIL sat_nocoll got %b want 0", coll1); end
        Enb = 1'b0; Addra = 12'd1; Dina = 32'h12345678; tick();
        Ena = 1'b0; Enb = 1'b1; Addrb = 12'd2; Dinb = 32'h5A5A5A5A; tick();
        idle();
        checks++; if (wrc1 !== 13'd7 || wrc2 !== 3'd4) begin errors++; $display("FAIL sat_final got %0d/%0d want 7/4", wrc1, wrc2); end
        // Read in flight when reset hits; a write attempted during reset must be dropped.
        Ena = 1'b1; Wea = 1'b0; Addra = 12'd0;
        tick();
        checks++; if (douta1 !== 32'hCAFEF00D || valida1 !== 1'b1 || valida2 !== 1'b0) begin errors++; $display("FAIL flight_pre got %h/%b/%b want CAFEF00D/1/0", douta1, valida1, valida2); end
        Rstn = 1'b0; Enb = 1'b1; Web = 1'b1; Addrb = 12'd2; Dinb = 32'hDEADDEAD;
        tick();
        checks++; if (valida1 !== 1'b0 || valida2 !== 1'b0 || douta1 !== 32'h0 || wrc1 !== 13'd0) begin errors++; $display("FAIL flight_rst got %b/%b/%h/%0d want 0/0/0/0", valida1, valida2, douta1, wrc1); end
        Rstn = 1'b1; idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valida1 !== 1'b0 || valida2 !== 1'b0 || wrc2 !== 3'd0) begin errors++; $display("FAIL flight_drop cyc %0d got %b/%b/%0d want 0/0/0", i, valida1, valida2, wrc2); end
        end
        Ena = 1'b1; Wea = 1'b0; Addra = 12'd0; Enb = 1'b1; Web = 1'b0; Addrb = 12'd2;
        tick();
        Addra = 12'd1; Addrb = 12'd1;
        checks++; if (douta1 !== 32'hCAFEF00D || doutb1 !== 32'h5A5A5A5A) begin errors++; $display("FAIL post_rst1 got %h/%h want CAFEF00D/5A5A5A5A", douta1, doutb1); end
        tick();
        idle();
        checks++; if (douta1 !== 32'h12345678 || doutb1 !== 32'h12345678) begin errors++; $display("FAIL same_rd1 got %h/%h want 12345678/12345678", douta1, doutb1); end
        checks++; if (douta2 !== 32'hCAFEF00D || doutb2 !== 32'h5A5A5A5A) begin errors++; $display("FAIL post_rst2 got %h/%h want CAFEF00D/5A5A5A5A", douta2, doutb2); end
        tick();
        checks++; if (douta2 !== 32'h12345678 || doutb2 !== 32'h12345678 || validb2 !== 1'b1) begin errors++; $display("FAIL same_rd2 got %h/%h/%b want 12345678/12345678/1", douta2, doutb2, validb2); end
        tick();
    endtask

`ifdef DPRAM_PARITY_EN
    task automatic test_parity();
        checks++; if (parerra1 !== 1'b0 || parerrb1 !== 1'b0) begin errors++; $display("FAIL par_idle got %b%b want 00", parerra1, parerrb1); end
        u1.mem[3] <= u1.mem[3] ^ 33'd1;
        #1;
        Ena = 1'b1; Wea = 1'b0; Addra = 12'd3;
        tick();
        Addra = 12'd0;
        checks++; if (valida1 !== 1'b1 || parerra1 !== 1'b1) begin errors++; $display("FAIL par_err got %b/%b want 1/1", valida1, parerra1); end
        checks++; if (douta1 !== 32'h0BADBEEE) begin errors++; $display("FAIL par_data got %h want 0BADBEEE", douta1); end
        tick();
        idle();
        checks++; if (valida1 !== 1'b1 || parerra1 !== 1'b0) begin errors++; $display("FAIL par_clean got %b/%b want 1/0", valida1, parerra1); end
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_rd_lat2();
        test_collision();
        test_rdw();
        test_saturate_reset();
`ifdef DPRAM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
